// File: rtl/boot_loader.sv
// Boot loader: receives a word count and program image over a byte stream,
// writes little-endian words to instruction memory and holds the core meanwhile.
module boot_loader #(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flash,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LEN   = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] ERROR = 3'd4;

  localparam int         TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] CAP = 17'(1 << ADDR_WIDTH);

  logic [2:0]            state;
  logic [2:0]            nxt;
  logic                  flash_q;
  logic [1:0]            idx;
  logic [7:0]            len_lo;
  logic [15:0]           len;
  logic [15:0]           n_rx;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [23:0]           shreg;
  logic [TW-1:0]         tcnt;
  logic                  expire;
  logic                  last;
  logic                  start;
  logic                  xfer;

  assign n_rx   = {byte_data, len_lo};
  assign expire = !byte_valid && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign last   = (17'(waddr) + 17'd1) == {1'b0, len};
  assign start  = (state == IDLE) && (nxt == LEN);
  assign xfer   = (state == LEN || state == LOAD) && (nxt != ERROR);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (flash && !flash_q) nxt = LEN;
      LEN: begin
        if (!flash || expire)
          nxt = ERROR;
        else if (byte_valid && idx[0])
          nxt = (n_rx == 16'd0 || {1'b0, n_rx} > CAP) ? ERROR : LOAD;
      end
      LOAD: begin
        if (!flash || expire)
          nxt = ERROR;
        else if (byte_valid && idx == 2'd3 && last)
          nxt = DONE;
      end
      DONE:    nxt = IDLE;
      ERROR:   if (!flash) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      flash_q    <= 1'b0;
      idx        <= '0;
      len_lo     <= '0;
      len        <= '0;
      waddr      <= '0;
      shreg      <= '0;
      tcnt       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_hold  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state     <= nxt;
      flash_q   <= flash;
      imem_we   <= 1'b0;
      done      <= (nxt == DONE);
      busy      <= (nxt == LEN || nxt == LOAD || nxt == DONE);
      core_hold <= (nxt != IDLE);
      if (nxt == ERROR)
        error <= 1'b1;
      else if (start)
        error <= 1'b0;
      if (start) begin
        idx   <= '0;
        waddr <= '0;
        tcnt  <= '0;
      end else if (xfer) begin
        if (!byte_valid) begin
          tcnt <= tcnt + 1'b1;
        end else begin
          tcnt <= '0;
          idx  <= idx + 2'd1;
          if (state == LEN) begin
            if (!idx[0]) begin
              len_lo <= byte_data;
            end else begin
              len <= n_rx;
              idx <= '0;
            end
          end else begin
            unique case (idx)
              2'd0: shreg[7:0]   <= byte_data;
              2'd1: shreg[15:8]  <= byte_data;
              2'd2: shreg[23:16] <= byte_data;
              default: begin
                imem_we    <= 1'b1;
                imem_wdata <= {byte_data, shreg};
                imem_addr  <= waddr;
                waddr      <= waddr + 1'b1;
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed self-checking bench for boot_loader (ADDR_WIDTH=2,
// TIMEOUT_CYCLES=8).
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        flash;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        imem_we;
  logic [1:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        error;

  int cmp = 0;
  int bad = 0;
  int cyc = 0;
  int wn  = 0;
  int dn  = 0;
  int wa [16];
  int wc [16];
  logic [31:0] wd [16];

  boot_loader #(.ADDR_WIDTH(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .flash(flash),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_hold(core_hold),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (imem_we && wn < 16) begin
      wa[wn] = int'(imem_addr);
      wd[wn] = imem_wdata;
      wc[wn] = cyc;
      wn++;
    end
    if (done) dn++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic start_xfer();
    flash = 1'b0;
    idle(1);
    flash = 1'b1;
    idle(1);
    wn = 0;
    dn = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0; flash = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    idle(2);
    cmp++;
    if ({imem_we, imem_addr, imem_wdata, core_hold, busy, done, error} !== 39'd0) begin
      bad++;
      $display("FAIL reset_outputs got we=%b a=%0d d=%h h=%b b=%b dn=%b e=%b want all 0",
               imem_we, imem_addr, imem_wdata, core_hold, busy, done, error);
    end
    rst = 1'b1;
    idle(1);
  endtask

  task automatic test_load2();
    start_xfer();
    cmp++;
    if ({core_hold, busy} !== 2'b11) begin
      bad++; $display("FAIL start_hold got %b want 11", {core_hold, busy});
    end
    send(8'h02); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    cmp++;
    if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 2'd0, 32'h12345678}) begin
      bad++; $display("FAIL load2_w0 got we=%b a=%0d d=%h want 1 0 12345678",
                      imem_we, imem_addr, imem_wdata);
    end
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    cmp++;
    if ({imem_we, imem_addr, imem_wdata, done, core_hold} !==
        {1'b1, 2'd1, 32'hDEADBEEF, 1'b1, 1'b1}) begin
      bad++; $display("FAIL load2_w1 got we=%b a=%0d d=%h done=%b hold=%b want 1 1 deadbeef 1 1",
                      imem_we, imem_addr, imem_wdata, done, core_hold);
    end
    idle(1);
    cmp++;
    if ({imem_we, core_hold, busy, done, error} !== 5'b0) begin
      bad++; $display("FAIL load2_end got we=%b h=%b b=%b dn=%b e=%b want 0",
                      imem_we, core_hold, busy, done, error);
    end
    cmp++;
    if (wn !== 2 || dn !== 1) begin
      bad++; $display("FAIL load2_counts got writes=%0d dones=%0d want 2 1", wn, dn);
    end
    send(8'h01); send(8'h00); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    idle(1);
    cmp++;
    if (busy !== 1'b0 || wn !== 2) begin
      bad++; $display("FAIL held_flash got busy=%b writes=%0d want 0 2", busy, wn);
    end
  endtask

  task automatic test_bad_len();
    start_xfer();
    send(8'h00); send(8'h00);
    cmp++;
    if ({error, busy, core_hold} !== 3'b101) begin
      bad++; $display("FAIL zero_len got e/b/h=%b want 101", {error, busy, core_hold});
    end
    flash = 1'b0;
    idle(1);
    cmp++;
    if ({error, core_hold} !== 2'b10) begin
      bad++; $display("FAIL err_sticky got e/h=%b want 10", {error, core_hold});
    end
    flash = 1'b1;
    idle(1);
    cmp++;
    if ({error, busy} !== 2'b01) begin
      bad++; $display("FAIL err_clear got e/b=%b want 01", {error, busy});
    end
    wn = 0;
    send(8'h05); send(8'h00);
    idle(2);
    cmp++;
    if (error !== 1'b1 || busy !== 1'b0 || wn !== 0) begin
      bad++; $display("FAIL over_len got e=%b b=%b writes=%0d want 1 0 0", error, busy, wn);
    end
    send(8'h04); send(8'h00);
    cmp++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL err_ignores_bytes got e=%b b=%b want 1 0", error, busy);
    end
    flash = 1'b0;
    idle(1);
  endtask

  task automatic test_timeout();
    start_xfer();
    send(8'h01); send(8'h00); send(8'h11); send(8'h22);
    idle(7);
    cmp++;
    if (error !== 1'b0) begin
      bad++; $display("FAIL timeout_early got e=%b want 0 after 7 idle", error);
    end
    idle(1);
    cmp++;
    if (error !== 1'b1 || busy !== 1'b0 || wn !== 0) begin
      bad++; $display("FAIL timeout_fire got e=%b b=%b writes=%0d want 1 0 0", error, busy, wn);
    end
    start_xfer();
    send(8'h01); send(8'h00); send(8'h11); send(8'h22);
    idle(7);
    send(8'h33);
    send(8'h44);
    cmp++;
    if ({error, imem_we, imem_addr, imem_wdata, done} !==
        {1'b0, 1'b1, 2'd0, 32'h44332211, 1'b1}) begin
      bad++; $display("FAIL timeout_byte_wins got e=%b we=%b a=%0d d=%h dn=%b want 0 1 0 44332211 1",
                      error, imem_we, imem_addr, imem_wdata, done);
    end
    flash = 1'b0;
    idle(2);
  endtask

  task automatic test_abort();
    start_xfer();
    send(8'h04); send(8'h00);
    for (int i = 0; i < 12; i++) send(8'(8'h40 + i));
    send(8'h4C);
    flash = 1'b0;
    idle(1);
    cmp++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL abort_err got e=%b b=%b want 1 0", error, busy);
    end
    idle(2);
    cmp++;
    if (wn !== 3 || wa[2] !== 2 || wd[2] !== 32'h4B4A4948) begin
      bad++; $display("FAIL abort_writes got n=%0d a=%0d d=%h want 3 2 4b4a4948",
                      wn, wa[2], wd[2]);
    end
  endtask

  task automatic test_reset_mid();
    start_xfer();
    send(8'h01); send(8'h00); send(8'hAA); send(8'hBB); send(8'hCC);
    rst = 1'b0;
    #1;
    cmp++;
    if ({imem_we, imem_addr, imem_wdata, core_hold, busy, done, error} !== 39'd0) begin
      bad++; $display("FAIL reset_mid got we=%b h=%b b=%b e=%b want 0",
                      imem_we, core_hold, busy, error);
    end
    flash = 1'b0;
    send(8'hDD);
    rst = 1'b1;
    idle(1);
    send(8'hEE);
    idle(1);
    cmp++;
    if (wn !== 0 || busy !== 1'b0 || core_hold !== 1'b0) begin
      bad++; $display("FAIL reset_no_write got writes=%0d b=%b h=%b want 0 0 0",
                      wn, busy, core_hold);
    end
  endtask

  task automatic test_back_to_back();
    start_xfer();
    send(8'h04); send(8'h00);
    byte_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      byte_data = 8'(i);
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b0;
    idle(2);
    cmp++;
    if (wn !== 4 || dn !== 1) begin
      bad++; $display("FAIL b2b_count got writes=%0d dones=%0d want 4 1", wn, dn);
    end
    for (int i = 0; i < 4 && i < wn; i++) begin
      cmp++;
      if (wa[i] !== i || wd[i] !== {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}) begin
        bad++; $display("FAIL b2b_word%0d got a=%0d d=%h", i, wa[i], wd[i]);
      end
      if (i > 0) begin
        cmp++;
        if (wc[i] - wc[i-1] !== 4) begin
          bad++; $display("FAIL b2b_gap%0d got %0d want 4", i, wc[i] - wc[i-1]);
        end
      end
    end
    flash = 1'b0;
    idle(2);
  endtask

  initial begin
    test_reset();
    test_load2();
    test_bad_len();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
# boot_loader

Instruction-memory boot loader and pipeline sequencer. It accepts a word count and program image as a byte stream from the UART receiver and assembles the bytes into 32-bit little-endian words. It writes each word into instruction memory and holds the core pipeline (PC, fetch and pipeline registers) stalled for the whole transfer. It sits between the UART interface, the instruction memory write port and the core's hold/flush input.

## Interface
- ADDR_WIDTH, 10: instruction-memory word-address width. Capacity is 2**ADDR_WIDTH words.
- TIMEOUT_CYCLES, 1000000: maximum idle clocks between bytes during a transfer. Must be ≥ 2.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous and active-low (0 = reset).
- flash  input  1  load request level from board; a transfer starts on its rising edge.
- byte_valid  input  1  single-cycle strobe from the UART receiver: byte_data is valid.
- byte_data  input  8  received byte.
- imem_we  output  1  instruction-memory write enable, one-cycle pulse per word.
- imem_addr  output  ADDR_WIDTH  word address for the write.
- imem_wdata  output  32  word data for the write.
- core_hold  output  1  stalls the core and flushes IF/ID while high.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse on successful completion.
- error  output  1  sticky error flag.

## Operation
- States: IDLE, LEN, LOAD, DONE, ERROR.
- IDLE
  - core_hold=0.
  - flash rising edge (flash=1 with registered previous flash=0) → LEN.
  - Entering LEN clears error, the byte index, the word address and the timeout counter.
  - byte_valid is ignored in IDLE.
- LEN
  - Receives 2 bytes forming a 16-bit word count N: first byte N[7:0], second byte N[15:8].
  - After the second byte: N==0 or N>2**ADDR_WIDTH → ERROR; otherwise → LOAD.
- LOAD
  - Byte index k=0..3 is placed at bits [8k+7:8k] of a word shift register.
  - On byte k=3: imem_wdata=assembled word, imem_addr=word address, imem_we=1; the word address then increments.
  - When the N-th word is written → DONE.
  - The word address never wraps: the N limit check guarantees the final address is N-1.
- DONE: exactly one cycle, done=1 and core_hold=1, then → IDLE.
- ERROR
  - error=1 and core_hold=1.
  - flash=0 → IDLE; error stays 1 until the next LEN entry.
- core_hold=1 and busy=1 in LEN, LOAD and DONE. busy=0 in IDLE and ERROR.
- Timeout
  - In LEN and LOAD a counter increments every cycle without byte_valid and clears on byte_valid.
  - When the counter reaches TIMEOUT_CYCLES → ERROR.
  - If byte_valid and expiry occur in the same cycle, the byte wins: it is accepted and the counter clears.
- flash deasserted during LEN or LOAD → ERROR on that edge (abort); the partial image is left in memory.
- flash held high after DONE does not restart a transfer; a new rising edge is required.

## Timing
- Reset (rst=0, asynchronous): state=IDLE; imem_we=0, imem_addr=0, imem_wdata=0, core_hold=0, busy=0, done=0, error=0; internal counters and previous-flash register = 0.
  - Reset asserted mid-transfer aborts immediately with the same values. No write completes after reset assertion.
- All outputs are registered.
- Start: a flash rising edge sampled at edge E puts core_hold=1 and busy=1 from E+1.
- Word write: byte_valid carrying byte 3, sampled at edge E → imem_we=1 during cycle E..E+1 only, with imem_addr/imem_wdata stable in that cycle.
- Back-to-back byte_valid on consecutive cycles is supported. Consecutive word writes can be as close as 4 cycles apart.
- Last word sampled at E → imem_we at E+1 and done=1 in the same cycle (DONE state), then core_hold=0 from E+2.
- Error entry at edge E → error=1, busy=0 from E+1.
- The timeout fires on the edge where the count equals TIMEOUT_CYCLES, i.e. after TIMEOUT_CYCLES consecutive cycles without byte_valid.

## Test plan
- Load 2 words: flash↑; bytes 02 00 78 56 34 12 EF BE AD DE → two imem_we pulses, (addr 0, 0x12345678) then (addr 1, 0xDEADBEEF); done pulses once in the cycle of the second write; core_hold falls the next cycle; error=0.
- Zero/oversize length with ADDR_WIDTH=2: counts 00 00 and 05 00 → ERROR, no imem_we, error=1. flash↓ → IDLE with error still 1. A new flash↑ clears error.
- Timeout with TIMEOUT_CYCLES=8: send 01 00 11 22, then silence → error=1 after 8 idle cycles, no write. Repeat with a byte on exactly the 8th idle cycle → byte accepted, no error.
- Abort: deassert flash after 1 of 4 bytes of word 3 → ERROR, only words 0–2 written.
- Reset mid-LOAD: rst=0 between bytes 2 and 3 → all outputs 0 immediately, no write. After release, a byte_valid alone produces nothing; flash held high without an edge does not start a transfer.
- Back-to-back strobes: 4 words delivered with byte_valid on every cycle → imem_we pulses exactly 4 cycles apart, addresses 0..3, correct data.
